// File: rtl/mem_access_if.sv
// Request/response channel between the CPU datapath and the RAM access sequencer.
// master = requester side, slave = the sequencer.
interface mem_access_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_rw;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rw, rsp_rdata
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rw, rsp_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding RAM access sequencer: holds en/rw/addr/A stable for HOLD_CYCLES clk
// cycles so the RAM's unrelated clock samples them, then captures Q and returns a response.
module mem_access_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_if.slave       bus,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [7:0]        access_count
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (HOLD_CYCLES < 2 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("mem_access_ctrl: HOLD_CYCLES must be within 2..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q,        state_d;
  logic [CNT_W-1:0]  hold_cnt_q,     hold_cnt_d;
  logic              mem_en_q,       mem_en_d;
  logic              mem_rw_q,       mem_rw_d;
  logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
  logic              rsp_valid_q,    rsp_valid_d;
  logic              rsp_rw_q,       rsp_rw_d;
  logic [DATA_W-1:0] rsp_rdata_q,    rsp_rdata_d;
  logic              req_ready_q,    req_ready_d;
  logic              busy_q,         busy_d;
  logic [7:0]        access_count_q, access_count_d;

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    mem_en_d       = mem_en_q;
    mem_rw_d       = mem_rw_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_rw_d       = rsp_rw_q;
    rsp_rdata_d    = rsp_rdata_q;
    req_ready_d    = req_ready_q;
    busy_d         = busy_q;
    access_count_d = access_count_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          mem_rw_d    = bus.req_rw;
          mem_addr_d  = bus.req_addr;
          mem_wdata_d = bus.req_wdata;
          hold_cnt_d  = HOLD_LOAD;
          mem_en_d    = 1'b1;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        // Q is sampled on the last edge of the hold window, while en is still asserted.
        if (hold_cnt_q == '0) begin
          rsp_rdata_d    = mem_rw_q ? mem_rdata : mem_wdata_q;
          rsp_rw_d       = mem_rw_q;
          access_count_d = access_count_q + 8'd1;
          mem_en_d       = 1'b0;
          rsp_valid_d    = 1'b1;
          state_d        = RESP;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        mem_en_d    = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      hold_cnt_q     <= '0;
      mem_en_q       <= 1'b0;
      mem_rw_q       <= 1'b1;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rw_q       <= 1'b1;
      rsp_rdata_q    <= '0;
      req_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      access_count_q <= '0;
    end else begin
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      mem_en_q       <= mem_en_d;
      mem_rw_q       <= mem_rw_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rw_q       <= rsp_rw_d;
      rsp_rdata_q    <= rsp_rdata_d;
      req_ready_q    <= req_ready_d;
      busy_q         <= busy_d;
      access_count_q <= access_count_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rw    = rsp_rw_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign mem_en        = mem_en_q;
  assign mem_rw        = mem_rw_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = busy_q;
  assign access_count  = access_count_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Request sequencer that sits directly upstream of the 16×16 RAM. It accepts single read/write requests from the CPU datapath over a valid/ready handshake and drives the RAM's `en`/`rw`/`addr`/`A` inputs. It holds those inputs stable long enough for the RAM's free-running internal clock to see them, then captures `Q` and returns the result over a valid/ready response channel. It runs on the processor clock; the RAM's clock is unrelated, so the stretched-hold window is the only synchronisation guarantee.

## Interface
- `ADDR_W`, default 4: RAM address width.
- `DATA_W`, default 16: data width.
- `HOLD_CYCLES`, default 4: clk cycles `mem_en` is held high per access.
  - Legal range is 2..15.
  - Must span at least one full RAM clock period plus one clk cycle.
- `clk`, input, 1: processor clock. All state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req_valid`, input, 1: request present.
- `req_ready`, output, 1: controller can accept a request.
- `req_rw`, input, 1: 1 = read, 0 = write (same encoding as the RAM).
- `req_addr`, input, ADDR_W: word address.
- `req_wdata`, input, DATA_W: write data. Ignored for reads.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_rw`, output, 1: echo of `req_rw` for this response.
- `rsp_rdata`, output, DATA_W: read data, or echo of write data for writes.
- `mem_en`, output, 1: to RAM `en`.
- `mem_rw`, output, 1: to RAM `rw`.
- `mem_addr`, output, ADDR_W: to RAM `addr`.
- `mem_wdata`, output, DATA_W: to RAM `A`.
- `mem_rdata`, input, DATA_W: from RAM `Q`.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `access_count`, output, 8: completed accesses. Wraps from 255 to 0.

## Operation
- **States:** IDLE, ACCESS, RESP. All outputs are registered or decoded from the state register only; there are no combinational paths from inputs to outputs.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch `req_rw`, `req_addr`, `req_wdata` into `mem_rw`, `mem_addr`, `mem_wdata`; load `hold_cnt`=HOLD_CYCLES-1; go to ACCESS.
- **ACCESS**
  - `mem_en`=1 and `req_ready`=0.
  - `mem_rw`, `mem_addr`, `mem_wdata` stay constant for the whole state.
  - `hold_cnt` decrements each cycle.
  - On the edge where `hold_cnt`==0:
    - For a read, `rsp_rdata` ← `mem_rdata`. For a write, `rsp_rdata` ← `mem_wdata`.
    - `rsp_rw` ← `mem_rw`.
    - `access_count` increments.
    - Go to RESP.
- **RESP**
  - `mem_en`=0, `rsp_valid`=1.
  - `rsp_rdata` and `rsp_rw` are stable until the handshake.
  - On `rsp_ready`, go to IDLE.
  - While `rsp_ready`=0, the controller stalls indefinitely. `mem_*` address and data hold their values but `mem_en` stays 0.
- **Access gap:** `mem_en` is low for at least 2 clk cycles between consecutive accesses (the RESP cycle plus the IDLE cycle). The RAM never sees back-to-back enables.
- **Ignored inputs:** requests arriving while `req_ready`=0 are not captured. The requester must hold them under valid/ready rules. `req_*` changes outside the accept edge have no effect.
- **Address range:** `req_addr` is full ADDR_W. Every value is legal; there is no error path.
- **Reset:**
  - `rst_n` low forces immediately, without waiting for clk: state IDLE, `mem_en`=0, `mem_rw`=1, `mem_addr`=0, `mem_wdata`=0, `rsp_valid`=0, `rsp_rw`=1, `rsp_rdata`=0, `hold_cnt`=0, `access_count`=0, `busy`=0.
  - `req_ready` is 1 while in reset and after release.
  - Reset asserted during ACCESS aborts the access. A write in progress may or may not have landed in the RAM; no response is produced.

## Timing
- Let t0 be the accept edge.
  - `mem_en` is high for exactly HOLD_CYCLES cycles, from after t0 to edge t0+HOLD_CYCLES.
  - `mem_rdata` is sampled at edge t0+HOLD_CYCLES.
  - `rsp_valid` rises after edge t0+HOLD_CYCLES, so request-to-response latency is HOLD_CYCLES cycles.
- If `rsp_ready` is already high, RESP lasts 1 cycle. The next request can then be accepted at edge t0+HOLD_CYCLES+2.
  - Peak throughput is one access per HOLD_CYCLES+2 cycles; that is 6 cycles at default.
- `busy` equals (state≠IDLE) and is registered alongside the state.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → all outputs take their reset values before the next clk edge; `req_ready`=1 after release.
- **Write then read:** write addr 4'h3, data 16'hBEEF, then read addr 4'h3, `rsp_ready` tied 1 →
  - `mem_en` high exactly 4 cycles each time;
  - write response echoes 16'hBEEF with `rsp_rw`=0;
  - read response returns 16'hBEEF with `rsp_rw`=1, 4 cycles after accept;
  - `access_count`=2.
- **Response backpressure:** read with `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_rdata` stable all 10 cycles; `mem_en`=0; `req_ready`=0; new `req_valid` is not accepted until 1 cycle after `rsp_ready`.
- **Back-to-back requests:** `req_valid` held high with 8 writes to addr 0..7 → accepts spaced exactly 6 cycles apart; `mem_en` low ≥2 cycles between bursts; readback of all 8 addresses matches.
- **Reset mid-access:** `rst_n` pulsed low at the 2nd ACCESS cycle of a read → `mem_en` drops immediately; no `rsp_valid`; `access_count`=0; the next request completes normally.
- **Counter wrap:** 256 completed accesses → `access_count` reads 0; HOLD_CYCLES=2 build repeats the write-then-read check with 2-cycle latency.
